// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared controller types, opcodes and datapath select encodings
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADR    = 4'd2,
        S_MEMREAD   = 4'd3,
        S_MEMWB     = 4'd4,
        S_MEMWRITE  = 4'd5,
        S_EXECUTER  = 4'd6,
        S_ALUWB     = 4'd7,
        S_EXECUTEI  = 4'd8,
        S_JAL       = 4'd9,
        S_BEQ       = 4'd10
    } statetype;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RESULT_ALUOUT    = 2'b00;
    localparam logic [1:0] RESULT_DATA      = 2'b01;
    localparam logic [1:0] RESULT_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    function automatic logic op_supported(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I) || (op == OP_JAL) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/main_fsm.sv
// rtl/main_fsm.sv - multicycle RISC-V main controller (Moore FSM)
module main_fsm
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       illegal_op,
    output logic [3:0] state
);

    statetype cur_state, nxt_state;
    logic     pc_update, branch, mem_write_raw, ir_write_raw, reg_write_raw;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cur_state <= S_FETCH;
        else          cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = S_FETCH;
        case (cur_state)
            S_FETCH:    nxt_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_R:         nxt_state = S_EXECUTER;
                    OP_I:         nxt_state = S_EXECUTEI;
                    OP_JAL:       nxt_state = S_JAL;
                    OP_BEQ:       nxt_state = S_BEQ;
                    default:      nxt_state = S_FETCH;
                endcase
            end
            S_MEMADR:   nxt_state = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  nxt_state = S_MEMWB;
            S_EXECUTER: nxt_state = S_ALUWB;
            S_EXECUTEI: nxt_state = S_ALUWB;
            S_JAL:      nxt_state = S_ALUWB;
            default:    nxt_state = S_FETCH;
        endcase
    end

    always_comb begin
        AdrSrc        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        ResultSrc     = RESULT_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RS2;
        ALUOp         = ALUOP_ADD;
        case (cur_state)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                pc_update    = 1'b1;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RESULT_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc     = RESULT_DATA;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB:    reg_write_raw = 1'b1;
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALUOP_SUB;
                branch  = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are masked by reset so nothing is written while the FSM is held.
    assign PCWrite    = reset_n & (pc_update | (branch & zero));
    assign IRWrite    = reset_n & ir_write_raw;
    assign MemWrite   = reset_n & mem_write_raw;
    assign RegWrite   = reset_n & reg_write_raw;
    assign illegal_op = (cur_state == S_DECODE) && !op_supported(op);
    assign state      = cur_state;

endmodule

// File: tb/tb_main_fsm.sv
// tb/tb_main_fsm.sv - randomized self-checking bench for main_fsm against a table model
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic       zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    // {AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, RegWrite, PCUpdate, Branch}
    logic [13:0] ctrl_tab [0:10];

    always #5 clk = ~clk;

    main_fsm dut (
        .clk(clk), .reset_n(reset_n), .op(op), .zero(zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .RegWrite(RegWrite), .illegal_op(illegal_op), .state(state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1101111 || o == 7'b1100011;
    endfunction

    task automatic check_state_outputs(input int s, input logic [6:0] o, input string who);
        logic [13:0] c;
        c = ctrl_tab[s];
        check({who, " state"},     state,     s);
        check({who, " AdrSrc"},    AdrSrc,    c[13]);
        check({who, " MemWrite"},  MemWrite,  c[12]);
        check({who, " IRWrite"},   IRWrite,   c[11]);
        check({who, " ResultSrc"}, ResultSrc, c[10:9]);
        check({who, " ALUSrcA"},   ALUSrcA,   c[8:7]);
        check({who, " ALUSrcB"},   ALUSrcB,   c[6:5]);
        check({who, " ALUOp"},     ALUOp,     c[4:3]);
        check({who, " RegWrite"},  RegWrite,  c[2]);
        check({who, " PCWrite"},   PCWrite,   c[1] | (c[0] & zero));
        check({who, " illegal"},   illegal_op, (s == 1) && !is_legal(o));
    endtask

    // Expected state walk per instruction class; called with the FSM in Fetch.
    task automatic run_instr(input logic [6:0] o, input string who);
        int seq [$];
        case (o)
            7'b0000011: seq = '{0, 1, 2, 3, 4};
            7'b0100011: seq = '{0, 1, 2, 5};
            7'b0110011: seq = '{0, 1, 6, 7};
            7'b0010011: seq = '{0, 1, 8, 7};
            7'b1101111: seq = '{0, 1, 9, 7};
            7'b1100011: seq = '{0, 1, 10};
            default:    seq = '{0, 1};
        endcase
        op = o;
        foreach (seq[i]) begin
            zero = 1'($urandom);
            #1;
            check_state_outputs(seq[i], o, who);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [6:0] r_op;
        logic [6:0] legal_ops [0:5];
        ctrl_tab[0]  = {1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0};
        ctrl_tab[1]  = {1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
        ctrl_tab[2]  = {1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
        ctrl_tab[3]  = {1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        ctrl_tab[4]  = {1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
        ctrl_tab[5]  = {1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        ctrl_tab[6]  = {1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0};
        ctrl_tab[7]  = {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
        ctrl_tab[8]  = {1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0};
        ctrl_tab[9]  = {1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0};
        ctrl_tab[10] = {1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1};
        legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};

        reset_n = 1'b0;
        op      = 7'b0110011;
        zero    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst state", state, 0);
        check("rst PCWrite", PCWrite, 0);
        check("rst IRWrite", IRWrite, 0);
        check("rst ALUSrcB", ALUSrcB, 2'b10);
        check("rst illegal", illegal_op, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rel IRWrite", IRWrite, 1);
        check("rel PCWrite", PCWrite, 1);

        run_instr(7'b0000011, "lw");
        run_instr(7'b0100011, "sw");
        run_instr(7'b0110011, "r");
        run_instr(7'b0010011, "i");
        op = 7'b1100011;
        zero = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("beq z1 state", state, 10);
        check("beq z1 PCWrite", PCWrite, 1);
        check("beq z1 ALUOp", ALUOp, 2'b01);
        zero = 1'b0;
        #1;
        check("beq z0 PCWrite", PCWrite, 0);
        @(posedge clk); #1;
        run_instr(7'b1101111, "jal");
        run_instr(7'b1111111, "ill");

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                do r_op = 7'($urandom); while (is_legal(r_op));
            end else begin
                r_op = legal_ops[$urandom_range(0, 5)];
            end
            run_instr(r_op, "rnd");
        end

        op = 7'b0000011;
        repeat (3) @(posedge clk);
        #1;
        check("mid lw state", state, 3);
        reset_n = 1'b0;
        #1;
        check("mid rst state", state, 0);
        check("mid rst RegWrite", RegWrite, 0);
        check("mid rst IRWrite", IRWrite, 0);
        @(posedge clk); #1;
        check("mid hold state", state, 0);
        check("mid hold RegWrite", RegWrite, 0);
        @(negedge clk);
        reset_n = 1'b1;
        run_instr(7'b0100011, "post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
